// File: rtl/jtopl_pg_rhy_src.sv
// jtopl_pg_rhy_src: rhythm-mode side signals (slot tracking, hh/tc phase latches, noise LFSR)
module jtopl_pg_rhy_src #(
  parameter logic [4:0]  NSLOTS    = 5'd18,
  parameter logic [4:0]  SLOT_HH   = 5'd13,
  parameter logic [4:0]  SLOT_SD   = 5'd16,
  parameter logic [4:0]  SLOT_TC   = 5'd17,
  parameter logic [22:0] LFSR_SEED = 23'h1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic       rhy_en,
  input  logic [9:0] phase_pre,
  output logic [4:0] slot,
  output logic       noise,
  output logic [9:0] hh,
  output logic       hh_en,
  output logic       sd_en,
  output logic       tc_en,
  output logic       rm_xor
);
  logic [4:0]  slot_d, slot_q;
  logic [9:0]  hh_d, hh_q, tc_d, tc_q;
  logic [22:0] lfsr_d, lfsr_q, lfsr_nx;
  logic        last;
  // next state: slot advance/resync, end-of-slot phase captures, once-per-sample LFSR step
  always_comb begin
    last    = slot_q == NSLOTS - 5'd1;
    lfsr_nx = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[8] ^ lfsr_q[7] ^ lfsr_q[0]};
    slot_d  = !cen ? slot_q : zero ? 5'd1 : last ? 5'd0 : slot_q + 5'd1;
    hh_d    = cen && slot_q == SLOT_HH ? phase_pre : hh_q;
    tc_d    = cen && slot_q == SLOT_TC ? phase_pre : tc_q;
    lfsr_d  = !(cen && last) ? lfsr_q : lfsr_nx == 23'd0 ? 23'h1 : lfsr_nx;
  end
  // state registers with synchronous reset taking priority over cen/zero
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= 5'd0;
      hh_q   <= 10'd0;
      tc_q   <= 10'd0;
      lfsr_q <= LFSR_SEED;
    end else begin
      slot_q <= slot_d;
      hh_q   <= hh_d;
      tc_q   <= tc_d;
      lfsr_q <= lfsr_d;
    end
  end
  assign slot   = slot_q;
  assign noise  = lfsr_q[22];
  assign hh     = hh_q;
  assign hh_en  = rhy_en && slot_q == SLOT_HH;
  assign sd_en  = rhy_en && slot_q == SLOT_SD;
  assign tc_en  = rhy_en && slot_q == SLOT_TC;
  assign rm_xor = (hh_q[2] ^ hh_q[7]) | (hh_q[3] ^ tc_q[5]) | (tc_q[3] ^ tc_q[5]);
endmodule

// File: tb/tb_jtopl_pg_rhy_src.sv
// tb_jtopl_pg_rhy_src: scoreboard bench for the rhythm source block
module tb_jtopl_pg_rhy_src;
  logic clk = 0, rst = 1, cen = 0, zero = 0, rhy_en = 0;
  logic [9:0] phase_pre = 0;
  logic [4:0] slot;
  logic noise, hh_en, sd_en, tc_en, rm_xor;
  logic [9:0] hh;
  int vecs = 0, errs = 0;
  logic [4:0] m_slot = 0;
  logic [9:0] m_hh = 0, m_tc = 0;
  logic [22:0] m_lfsr = 23'h1;
  logic [19:0] sb[$];
  logic [19:0] exp_v;

  jtopl_pg_rhy_src dut (.clk(clk), .rst(rst), .cen(cen), .zero(zero), .rhy_en(rhy_en),
    .phase_pre(phase_pre), .slot(slot), .noise(noise), .hh(hh), .hh_en(hh_en),
    .sd_en(sd_en), .tc_en(tc_en), .rm_xor(rm_xor));

  always #5 clk = ~clk;

  function automatic logic [19:0] obs();
    return {slot, noise, hh, hh_en, sd_en, tc_en, rm_xor};
  endfunction

  // drive one clock of stimulus, update the behavioural model and push its expectation
  task automatic cyc(input logic r, input logic c, input logic z, input logic h, input logic [9:0] p);
    logic [22:0] nx;
    logic rx;
    rst = r; cen = c; zero = z; rhy_en = h; phase_pre = p;
    if (r) begin
      m_slot = 0; m_hh = 0; m_tc = 0; m_lfsr = 23'h1;
    end else if (c) begin
      if (m_slot == 13) m_hh = p;
      if (m_slot == 17) begin
        m_tc = p;
        nx = m_lfsr << 1;
        nx[0] = m_lfsr[22] ^ m_lfsr[8] ^ m_lfsr[7] ^ m_lfsr[0];
        m_lfsr = (nx == 0) ? 23'h1 : nx;
      end
      if (z) m_slot = 1;
      else if (m_slot == 17) m_slot = 0;
      else m_slot = m_slot + 1;
    end
    rx = (m_hh[2] != m_hh[7]) || (m_hh[3] != m_tc[5]) || (m_tc[3] != m_tc[5]);
    sb.push_back({m_slot, m_lfsr[22], m_hh, h && m_slot == 13, h && m_slot == 16, h && m_slot == 17, rx});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, i[0], 1, 1, 10'h3ff);
      exp_v = sb.pop_front(); vecs++;
      if (obs() !== exp_v) begin errs++; $display("FAIL reset got=%h exp=%h", obs(), exp_v); end
    end
    vecs++;
    if ({slot, hh, noise, rm_xor, hh_en} !== 18'd0) begin
      errs++; $display("FAIL reset_const slot=%0d hh=%h noise=%b rm=%b", slot, hh, noise, rm_xor);
    end
  endtask

  task automatic test_slot_seq();
    int nh, ns, nt;
    for (int pass = 0; pass < 2; pass++) begin
      nh = 0; ns = 0; nt = 0;
      cyc(1, 0, 0, 0, 0); void'(sb.pop_front());
      for (int i = 0; i < 18; i++) begin
        cyc(0, 1, 0, pass == 0, 0);
        exp_v = sb.pop_front(); vecs++;
        if (obs() !== exp_v) begin errs++; $display("FAIL slot_seq got=%h exp=%h", obs(), exp_v); end
        if (hh_en) nh++;
        if (sd_en) ns++;
        if (tc_en) nt++;
        vecs++;
        if (slot !== 5'((i + 1) % 18)) begin errs++; $display("FAIL slot_count got=%0d exp=%0d", slot, (i + 1) % 18); end
      end
      vecs++;
      if ({nh, ns, nt} !== (pass == 0 ? {32'd1, 32'd1, 32'd1} : 96'd0)) begin
        errs++; $display("FAIL enable_counts pass=%0d hh=%0d sd=%0d tc=%0d", pass, nh, ns, nt);
      end
    end
  endtask

  task automatic test_noise();
    cyc(1, 0, 0, 0, 0); void'(sb.pop_front());
    for (int i = 0; i < 30 * 18; i++) begin
      cyc(0, 1, 0, 1, 10'($urandom_range(0, 1023)));
      exp_v = sb.pop_front(); vecs++;
      if (obs() !== exp_v) begin errs++; $display("FAIL noise_run cyc=%0d got=%h exp=%h", i, obs(), exp_v); end
      if (i == 3 * 18 - 1) begin
        vecs++;
        if (noise !== 1'b0) begin errs++; $display("FAIL noise_early got=%b exp=0", noise); end
      end
    end
  endtask

  task automatic test_rm_xor();
    cyc(1, 0, 0, 0, 0); void'(sb.pop_front());
    for (int i = 0; i < 36; i++) begin
      cyc(0, 1, 0, 0, i == 13 ? 10'h084 : i == 31 ? 10'h004 : 10'h000);
      exp_v = sb.pop_front(); vecs++;
      if (obs() !== exp_v) begin errs++; $display("FAIL rm_xor got=%h exp=%h", obs(), exp_v); end
      if (i == 13) begin
        vecs++;
        if ({hh, rm_xor} !== {10'h084, 1'b0}) begin errs++; $display("FAIL hh_cap hh=%h rm=%b exp hh=084 rm=0", hh, rm_xor); end
      end
      if (i == 31) begin
        vecs++;
        if ({hh, rm_xor} !== {10'h004, 1'b1}) begin errs++; $display("FAIL hh_cap2 hh=%h rm=%b exp hh=004 rm=1", hh, rm_xor); end
      end
    end
  endtask

  task automatic test_tc();
    cyc(1, 0, 0, 0, 0); void'(sb.pop_front());
    for (int i = 0; i < 19; i++) begin
      cyc(0, 1, 0, 1, i == 17 ? 10'h020 : 10'h000);
      exp_v = sb.pop_front(); vecs++;
      if (obs() !== exp_v) begin errs++; $display("FAIL tc_cap got=%h exp=%h", obs(), exp_v); end
      if (i == 17) begin
        vecs++;
        if ({slot, hh, rm_xor} !== {5'd0, 10'h000, 1'b1}) begin
          errs++; $display("FAIL tc_rm slot=%0d hh=%h rm=%b exp slot=0 hh=000 rm=1", slot, hh, rm_xor);
        end
      end
    end
  endtask

  task automatic test_zero_cen();
    logic [19:0] held;
    cyc(1, 0, 0, 0, 0); void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      if (i < 7) cyc(0, 1, 0, 1, 10'h0a5);
      else if (i == 7) cyc(0, 1, 1, 1, 10'h0a5);
      else if (i < 11) cyc(0, 1, 0, 1, 10'h3c3);
      else if (i == 11) cyc(0, 0, 1, 1, 10'h111);
      else if (i < 17) cyc(0, 0, 0, 1, 10'h2f0);
      else cyc(0, 1, 0, 1, 10'h000);
      exp_v = sb.pop_front(); vecs++;
      if (obs() !== exp_v) begin errs++; $display("FAIL zero_cen step=%0d got=%h exp=%h", i, obs(), exp_v); end
      if (i == 7) begin
        vecs++;
        if (slot !== 5'd1) begin errs++; $display("FAIL zero_resync got=%0d exp=1", slot); end
      end
      if (i == 11) held = obs();
      if (i == 16) begin
        vecs++;
        if (obs() !== held || slot !== 5'd4) begin errs++; $display("FAIL cen_freeze got=%h exp=%h", obs(), held); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0, 0); void'(sb.pop_front());
    for (int i = 0; i < 16; i++) begin
      if (i < 15) cyc(0, 1, 0, 1, 10'h2ac);
      else cyc(1, 1, 1, 1, 10'h2ac);
      exp_v = sb.pop_front(); vecs++;
      if (obs() !== exp_v) begin errs++; $display("FAIL reset_mid got=%h exp=%h", obs(), exp_v); end
    end
    vecs++;
    if ({slot, hh, rm_xor, noise} !== 17'd0) begin
      errs++; $display("FAIL reset_mid_const slot=%0d hh=%h rm=%b noise=%b", slot, hh, rm_xor, noise);
    end
  endtask

  initial begin
    test_reset();
    test_slot_seq();
    test_noise();
    test_rm_xor();
    test_tc();
    test_zero_cen();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
